// File: rtl/div_pkg.sv
// Shared types and constants for the iterative restoring divider.
package div_pkg;

  localparam int unsigned DIV_ITERS = 32;
  localparam int unsigned CNT_W     = 6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } div_state_t;

  // Two's complement negation with the width of the operand preserved.
  function automatic logic [31:0] neg32(input logic [31:0] x);
    return ~x + 32'(1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring step: shift the next dividend bit into the remainder
// and subtract the divisor when it fits.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quot,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_c,
  output logic [WIDTH-1:0] quot_c
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;

  always_comb begin
    shifted = {rem, quot[WIDTH-1]};
    // remainder stays below the divisor, so the difference always fits WIDTH bits
    diff    = shifted[WIDTH-1:0] - dvs;
    if (shifted >= {1'b0, dvs}) begin
      rem_c  = diff;
      quot_c = {quot[WIDTH-2:0], 1'b1};
    end else begin
      rem_c  = shifted[WIDTH-1:0];
      quot_c = {quot[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_unit.sv
// Fixed-latency 32-bit signed/unsigned divider with ARM zero-divide semantics.
module div_unit
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic             Signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             DivByZero,
  output logic [3:0]       DivFlags
);

  div_state_t       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [WIDTH-1:0] rem, rem_n, quo, quo_n, dvs, dvs_n;
  logic             neg_r, neg_r_n, neg_q, neg_q_n;
  logic [WIDTH-1:0] q_out_n, r_out_n;
  logic             dbz_n, busy_n, done_n;
  logic [3:0]       flags_n;
  logic [WIDTH-1:0] step_rem_c, step_quo_c;
  logic [WIDTH-1:0] q_fix, r_fix;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem    (rem),
    .quot   (quo),
    .dvs    (dvs),
    .rem_c  (step_rem_c),
    .quot_c (step_quo_c)
  );

  assign q_fix = neg_q ? neg32(quo) : quo;
  assign r_fix = neg_r ? neg32(rem) : rem;

  // Next-state and next-register values; everything holds unless changed.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    rem_n   = rem;
    quo_n   = quo;
    dvs_n   = dvs;
    neg_r_n = neg_r;
    neg_q_n = neg_q;
    q_out_n = Quotient;
    r_out_n = Remainder;
    dbz_n   = DivByZero;
    flags_n = DivFlags;

    unique case (state)
      S_IDLE: begin
        if (Start) begin
          if (b == '0) begin
            state_n = S_DONE;
            q_out_n = '0;
            r_out_n = a;
            dbz_n   = 1'b1;
            flags_n = 4'b0100;
          end else begin
            state_n = S_ITER;
            cnt_n   = CNT_W'(DIV_ITERS - 1);
            rem_n   = '0;
            quo_n   = (Signed && a[WIDTH-1]) ? neg32(a) : a;
            dvs_n   = (Signed && b[WIDTH-1]) ? neg32(b) : b;
            neg_r_n = Signed & a[WIDTH-1];
            neg_q_n = Signed & (a[WIDTH-1] ^ b[WIDTH-1]);
          end
        end
      end
      S_ITER: begin
        rem_n = step_rem_c;
        quo_n = step_quo_c;
        if (cnt == '0) state_n = S_FIX;
        else           cnt_n   = cnt - CNT_W'(1);
      end
      S_FIX: begin
        state_n = S_DONE;
        q_out_n = q_fix;
        r_out_n = r_fix;
        dbz_n   = 1'b0;
        flags_n = {q_fix[WIDTH-1], (q_fix == '0), 2'b00};
      end
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase

    busy_n = (state_n != S_IDLE);
    done_n = (state_n == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      rem       <= '0;
      quo       <= '0;
      dvs       <= '0;
      neg_r     <= 1'b0;
      neg_q     <= 1'b0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      Quotient  <= '0;
      Remainder <= '0;
      DivByZero <= 1'b0;
      DivFlags  <= 4'b0000;
    end else begin
      cnt       <= cnt_n;
      rem       <= rem_n;
      quo       <= quo_n;
      dvs       <= dvs_n;
      neg_r     <= neg_r_n;
      neg_q     <= neg_q_n;
      Busy      <= busy_n;
      Done      <= done_n;
      Quotient  <= q_out_n;
      Remainder <= r_out_n;
      DivByZero <= dbz_n;
      DivFlags  <= flags_n;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus random ops
// against an arithmetic reference model.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic        Signed;
  logic [31:0] a, b;
  logic        Busy, Done, DivByZero;
  logic [31:0] Quotient, Remainder;
  logic [3:0]  DivFlags;

  int total = 0;
  int bad   = 0;

  div_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .Start     (Start),
    .Signed    (Signed),
    .a         (a),
    .b         (b),
    .Busy      (Busy),
    .Done      (Done),
    .Quotient  (Quotient),
    .Remainder (Remainder),
    .DivByZero (DivByZero),
    .DivFlags  (DivFlags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic, truncating division, ARM /0 result.
  function automatic void model(input logic sg, input logic [31:0] av, input logic [31:0] bv,
                                output logic [31:0] q, output logic [31:0] r);
    longint sa, sb;
    if (bv == 32'd0) begin
      q = 32'd0;
      r = av;
    end else if (sg) begin
      sa = $signed(av);
      sb = $signed(bv);
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end else begin
      q = av / bv;
      r = av % bv;
    end
  endfunction

  // Called right after a negedge; Start is raised in that cycle (cycle 0).
  task automatic run_op(input string tag, input logic sg, input logic [31:0] av,
                        input logic [31:0] bv, input int second_at,
                        output logic [31:0] qo, output logic [31:0] ro);
    logic [31:0] eq, er;
    logic [3:0]  ef;
    int lat, done_at, busy_cnt;
    model(sg, av, bv, eq, er);
    ef  = {eq[31], (eq == 32'd0), 2'b00};
    lat = (bv == 32'd0) ? 1 : 34;
    done_at = -1;
    busy_cnt = 0;
    qo = 32'd0;
    ro = 32'd0;
    Start = 1'b1; Signed = sg; a = av; b = bv;
    for (int k = 1; k <= lat + 1; k++) begin
      @(negedge clk);
      if (k <= lat && Busy) busy_cnt++;
      if (Done && done_at < 0) begin
        done_at = k;
        qo = Quotient;
        ro = Remainder;
        chk({tag, ".q"},   64'(Quotient),  64'(eq));
        chk({tag, ".r"},   64'(Remainder), 64'(er));
        chk({tag, ".dbz"}, 64'(DivByZero), 64'(bv == 32'd0));
        chk({tag, ".flg"}, 64'(DivFlags),  64'(ef));
      end
      if (k == second_at) begin
        Start = 1'b1; a = 32'd1; b = 32'd1;
      end else begin
        Start = 1'b0; a = $urandom; b = $urandom;
      end
    end
    chk({tag, ".lat"},  64'(done_at), 64'(lat));
    chk({tag, ".busy"}, 64'(busy_cnt), 64'(lat));
    chk({tag, ".idle"}, 64'({Busy, Done}), 64'(0));
    chk({tag, ".hold"}, 64'(Quotient), 64'(eq));
  endtask

  logic [31:0] q, r;
  logic        sg;
  logic [31:0] ra, rb;

  initial begin
    reset = 1'b1; Start = 1'b0; Signed = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("rst.out", 64'({Busy, Done, DivByZero, DivFlags}), 64'(0));
    chk("rst.qr",  64'({Quotient, Remainder}), 64'(0));
    reset = 1'b0;
    @(negedge clk);

    run_op("udiv100", 1'b0, 32'd100, 32'd7, 0, q, r);
    chk("udiv100.q14", 64'(q), 64'd14);
    chk("udiv100.r2",  64'(r), 64'd2);
    run_op("sdiv-7", 1'b1, 32'hFFFF_FFF9, 32'd2, 0, q, r);
    chk("sdiv-7.qk", 64'(q), 64'h0000_0000_FFFF_FFFD);
    chk("sdiv-7.rk", 64'(r), 64'h0000_0000_FFFF_FFFF);
    run_op("div0", 1'b0, 32'd5, 32'd0, 0, q, r);
    chk("div0.rk", 64'(r), 64'd5);
    run_op("sdivovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, q, r);
    chk("sdivovf.qk", 64'(q), 64'h0000_0000_8000_0000);
    run_op("ignore", 1'b0, 32'hFFFF_FFFF, 32'd1, 5, q, r);
    chk("ignore.qk", 64'(q), 64'h0000_0000_FFFF_FFFF);
    run_op("sdiv0", 1'b1, 32'hFFFF_FF00, 32'd0, 0, q, r);

    // Reset in cycle 10 of an operation.
    Start = 1'b1; Signed = 1'b0; a = 32'd1000; b = 32'd3;
    @(negedge clk);
    Start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst.out", 64'({Busy, Done, DivByZero, DivFlags}), 64'(0));
    chk("midrst.qr",  64'({Quotient, Remainder}), 64'(0));
    begin
      int seen = 0;
      repeat (3) begin
        @(negedge clk);
        if (Done) seen++;
      end
      reset = 1'b0;
      repeat (30) begin
        @(negedge clk);
        if (Done) seen++;
      end
      chk("midrst.nodone", 64'(seen), 64'd0);
    end
    run_op("postrst", 1'b0, 32'd100, 32'd7, 0, q, r);
    chk("postrst.q14", 64'(q), 64'd14);
    chk("postrst.r2",  64'(r), 64'd2);

    for (int i = 0; i < 24; i++) begin
      sg = 1'($urandom_range(0, 1));
      ra = $urandom;
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = 32'($urandom_range(1, 15));
        3:       rb = ra;
        default: rb = $urandom;
      endcase
      if (i % 7 == 3) ra = 32'h8000_0000;
      run_op($sformatf("rnd%0d", i), sg, ra, rb, (i % 5 == 0) ? 3 : 0, q, r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand/result width; only 32 is supported for the ARM core.
REQ-002 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1: reset, asynchronous, active-high.
REQ-004 SHALL have port Start  input  1: request a division; sampled only in IDLE.
REQ-005 SHALL have port Signed  input  1: 1 = SDIV (two's complement), 0 = UDIV; sampled with Start.
REQ-006 SHALL have ports a, b  input  WIDTH each: dividend and divisor; sampled with Start.
REQ-007 SHALL have port Busy  output  1: high in every state except IDLE.
REQ-008 SHALL have port Done  output  1: single-cycle completion pulse.
REQ-009 SHALL have ports Quotient, Remainder  output  WIDTH each: results.
REQ-010 SHALL have port DivByZero  output  1: last completed operation had b == 0.
REQ-011 SHALL have port DivFlags  output  4: {N, Z, C, V}, same ordering as the core's ALUFlags.

Function
REQ-012 SHALL implement FSM states IDLE, ITER, FIX, DONE.
- IDLE to ITER on Start with b != 0.
- IDLE to DONE on Start with b == 0.
- ITER to FIX after 32 ITER cycles.
- FIX to DONE; DONE to IDLE unconditionally.
REQ-013 SHALL, on Start accept, latch |a| and |b| when Signed = 1, or a and b raw when Signed = 0, plus sign(a) and sign(a)^sign(b).
REQ-014 SHALL perform one radix-2 restoring step per ITER cycle, producing one quotient bit MSB-first, using a 6-bit down-counter loaded with 31.
REQ-015 SHALL, in FIX:
- negate the quotient magnitude if Signed and the signs differ;
- negate the remainder magnitude if Signed and a was negative (remainder sign follows dividend).
REQ-016 SHALL give fixed latency: Start in cycle 0, Done = 1 in cycle 34 for b != 0, and in cycle 1 for b == 0.
REQ-017 SHALL, for b == 0, produce Quotient = 0, Remainder = a and DivByZero = 1 (ARM zero-divide semantics); DivByZero SHALL otherwise be 0.
REQ-018 SHALL produce Quotient = 0x80000000 and Remainder = 0 for SDIV of 0x80000000 by 0xFFFFFFFF, with no special case needed.
REQ-019 SHALL compute DivFlags as N = Quotient[31], Z = (Quotient == 0), C = 0, V = 0.
REQ-020 SHALL update Quotient, Remainder, DivByZero and DivFlags only in the cycle Done rises, then hold them until the next completion.
REQ-021 SHALL ignore Start while Busy = 1, with no restart and no queuing.
REQ-022 SHALL accept a Start in the cycle after DONE, giving back-to-back operations 35 cycles apart.

Reset
REQ-023 SHALL, on reset assertion, immediately force state IDLE, Busy = 0, Done = 0, Quotient = 0, Remainder = 0, DivByZero = 0, DivFlags = 4'b0000 and counter = 0.
REQ-024 SHALL abandon any operation in progress on reset mid-operation, with no Done pulse; the first Start after reset deassertion SHALL be serviced normally.

Structure
REQ-025 SHALL take from a shared package div_pkg: the state enumeration, DIV_ITERS = 32, and the counter width.
REQ-026 SHALL use one sub-module, div_step: a combinational single restoring step {rem, quot} -> {rem', quot'} against the divisor.
REQ-027 SHALL keep the RTL within 120-400 lines, with no multiplier or division operator.

Verification
REQ-028 UDIV: a = 100, b = 7, Start in cycle 0 -> Done only in cycle 34, Quotient = 14, Remainder = 2, DivFlags = 0000, Busy = 1 in cycles 1-34.
REQ-029 SDIV: a = 0xFFFFFFF9 (-7), b = 2 -> Quotient = 0xFFFFFFFD, Remainder = 0xFFFFFFFF, DivFlags = 1000.
REQ-030 Zero divide: a = 5, b = 0 -> Done in cycle 1, Quotient = 0, Remainder = 5, DivByZero = 1, DivFlags = 0100.
REQ-031 SDIV overflow: a = 0x80000000, b = 0xFFFFFFFF -> Quotient = 0x80000000, Remainder = 0, DivFlags = 1000.
REQ-032 UDIV a = 0xFFFFFFFF, b = 1 with a second Start in cycle 5 (a = 1, b = 1) -> the second Start is ignored; Quotient = 0xFFFFFFFF, Remainder = 0 in cycle 34.
REQ-033 Reset asserted in cycle 10 of an operation -> all outputs 0 at once; no Done; a new 100 / 7 issued afterwards completes with Quotient = 14 and Remainder = 2.
